// File: rtl/jtframe_mist_upload_if.sv
// jtframe_mist_upload_if: SPI data-io lines plus the ioctl memory fetch port of the upload block
interface jtframe_mist_upload_if #(parameter int AW = 25);
    logic          spi_sck;
    logic          spi_ss;
    logic          spi_di;
    logic          spi_do;
    logic          spi_do_oe;
    logic [AW-1:0] ioctl_addr;
    logic          ioctl_rd;
    logic [7:0]    ioctl_din;
    logic          ioctl_ram;
    logic          uploading;
    modport master (
        output spi_sck, spi_ss, spi_di, ioctl_din,
        input  spi_do, spi_do_oe, ioctl_addr, ioctl_rd, ioctl_ram, uploading
    );
    modport slave (
        input  spi_sck, spi_ss, spi_di, ioctl_din,
        output spi_do, spi_do_oe, ioctl_addr, ioctl_rd, ioctl_ram, uploading
    );
endinterface

// File: rtl/jtframe_mist_upload.sv
// jtframe_mist_upload: SPI_SS2 responder that streams core memory back to the ARM io controller
module jtframe_mist_upload #(
    parameter int         AW      = 25,
    parameter int         RDLAT   = 2,
    parameter logic [7:0] CMD_UP  = 8'h57,
    parameter logic [7:0] CMD_DAT = 8'h58
)(
    input logic clk,
    input logic rst_n,
    jtframe_mist_upload_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, ARG, DAT, SKIP} state_t;
    state_t state;
    logic [2:0] sck_r, ss_r;
    logic [1:0] di_r;
    logic [6:0] rx;
    logic [7:0] rx_nxt, tx, txbuf;
    logic [2:0] bitcnt;
    logic [RDLAT-1:0] rd_pipe;
    logic [AW-1:0] addr;
    logic rd, ram, up, pend, first, reload;
    logic ss, ss_fall, sck_rise, sck_fall, byte_done;
    assign ss        = ss_r[1];
    assign ss_fall   = ~ss_r[1] & ss_r[2];
    assign sck_rise  = sck_r[1] & ~sck_r[2];
    assign sck_fall  = ~sck_r[1] & sck_r[2];
    assign rx_nxt    = {rx, di_r[1]};
    assign byte_done = sck_rise && bitcnt == 3'd7 && state != IDLE;
    assign bus.spi_do_oe  = state == DAT;
    assign bus.spi_do     = state == DAT ? tx[7] : 1'b1;
    assign bus.ioctl_addr = addr;
    assign bus.ioctl_rd   = rd;
    assign bus.ioctl_ram  = ram;
    assign bus.uploading  = up;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sck_r   <= '0;
            ss_r    <= '1;
            di_r    <= '0;
            rx      <= '0;
            tx      <= '1;
            txbuf   <= '1;
            bitcnt  <= '0;
            rd_pipe <= '0;
            addr    <= '0;
            rd      <= 1'b0;
            ram     <= 1'b0;
            up      <= 1'b0;
            pend    <= 1'b0;
            first   <= 1'b0;
            reload  <= 1'b0;
        end else begin
            sck_r   <= {sck_r[1:0], bus.spi_sck};
            ss_r    <= {ss_r[1:0], bus.spi_ss};
            di_r    <= {di_r[0], bus.spi_di};
            rd_pipe <= {rd_pipe[RDLAT-2:0], rd};
            rd      <= 1'b0;
            pend    <= 1'b0;
            if (rd_pipe[RDLAT-1]) begin
                txbuf <= bus.ioctl_din;
                if (first) begin
                    tx    <= bus.ioctl_din;
                    first <= 1'b0;
                end
            end
            if (ss) begin
                state  <= IDLE;
                bitcnt <= '0;
                reload <= 1'b0;
                first  <= 1'b0;
            end else begin
                if (sck_rise && state != IDLE) begin
                    rx     <= rx_nxt[6:0];
                    bitcnt <= bitcnt + 3'd1;
                end
                case (state)
                    IDLE: if (ss_fall) begin
                        state  <= CMD;
                        bitcnt <= '0;
                    end
                    CMD: if (byte_done) begin
                        state <= rx_nxt == CMD_UP ? ARG : (rx_nxt == CMD_DAT && up) ? DAT : SKIP;
                        if (rx_nxt == CMD_DAT && up) begin
                            rd     <= 1'b1;
                            first  <= 1'b1;
                            reload <= 1'b1;
                        end
                    end
                    ARG: if (byte_done) begin
                        state <= SKIP;
                        if (rx_nxt == 8'hFF) begin
                            up   <= 1'b1;
                            ram  <= 1'b1;
                            addr <= '0;
                        end else if (rx_nxt == 8'h00) begin
                            up   <= 1'b0;
                            ram  <= 1'b0;
                        end
                    end
                    DAT: begin
                        if (byte_done) begin
                            addr   <= addr + AW'(1);
                            pend   <= 1'b1;
                            reload <= 1'b1;
                        end
                        if (pend) rd <= 1'b1;
                        // the fall after a finished byte presents the prefetched byte
                        if (sck_fall) begin
                            tx     <= reload ? txbuf : {tx[6:0], 1'b1};
                            reload <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtframe_mist_upload.sv
// tb_jtframe_mist_upload: directed SPI transactions against a full-width and a 4-bit-address instance
`timescale 1ns/1ps
module tb_jtframe_mist_upload;
    localparam int HP = 100;
    logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, di = 1'b0;
    logic [1:0] ss = 2'b11;
    logic [7:0] d1_0, din0, d1_1, din1, r;
    int n_chk = 0, n_fail = 0, rd_cnt = 0, oe_cnt = 0;
    jtframe_mist_upload_if #(.AW(25)) b0 ();
    jtframe_mist_upload_if #(.AW(4))  b1 ();
    assign b0.spi_sck = sck;
    assign b0.spi_di  = di;
    assign b0.spi_ss  = ss[0];
    assign b0.ioctl_din = din0;
    assign b1.spi_sck = sck;
    assign b1.spi_di  = di;
    assign b1.spi_ss  = ss[1];
    assign b1.ioctl_din = din1;
    jtframe_mist_upload #(.AW(25)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    jtframe_mist_upload #(.AW(4))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    always #5 clk = ~clk;
    // memory holds addr n = n ^ 8'hA5, two-cycle read latency
    always @(posedge clk) begin
        if (b0.ioctl_rd) d1_0 <= b0.ioctl_addr[7:0] ^ 8'hA5;
        din0 <= d1_0;
        if (b1.ioctl_rd) d1_1 <= {4'h0, b1.ioctl_addr} ^ 8'hA5;
        din1 <= d1_1;
    end
    always @(negedge clk) begin
        if (b0.ioctl_rd) rd_cnt++;
        if (b0.spi_do_oe) oe_cnt++;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic bits(input int s, input logic [7:0] v, input int n, output logic [7:0] q);
        q = '0;
        for (int i = 7; i > 7 - n; i--) begin
            di = v[i];
            #(HP);
            q[i] = s ? b1.spi_do : b0.spi_do;
            sck = 1'b1;
            #(HP);
            sck = 1'b0;
        end
    endtask
    task automatic xfer(input int s, input logic [7:0] v, output logic [7:0] q);
        bits(s, v, 8, q);
    endtask
    task automatic sel(input int s);
        ss[s] = 1'b0;
        #(2*HP);
    endtask
    task automatic desel(input int s);
        #(HP);
        ss[s] = 1'b1;
        #(2*HP);
    endtask
    task automatic cmd2(input int s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q;
        sel(s);
        xfer(s, a, q);
        xfer(s, b, q);
        desel(s);
    endtask
    initial begin
        #23;
        chk("rst_do", b0.spi_do, 1);
        chk("rst_oe", b0.spi_do_oe, 0);
        chk("rst_addr", b0.ioctl_addr, 0);
        chk("rst_rd", b0.ioctl_rd, 0);
        chk("rst_ram", b0.ioctl_ram, 0);
        chk("rst_up", b0.uploading, 0);
        rst_n = 1'b1;
        #50;
        cmd2(0, 8'h57, 8'hFF);
        chk("start_up", b0.uploading, 1);
        chk("start_ram", b0.ioctl_ram, 1);
        chk("start_addr", b0.ioctl_addr, 0);
        cmd2(0, 8'h57, 8'h00);
        chk("stop_up", b0.uploading, 0);
        chk("stop_ram", b0.ioctl_ram, 0);
        rd_cnt = 0; oe_cnt = 0;
        cmd2(0, 8'h58, 8'h00);
        chk("gate_idle_rd", rd_cnt, 0);
        chk("gate_idle_oe", oe_cnt, 0);
        cmd2(0, 8'h57, 8'hFF);
        sel(0);
        xfer(0, 8'h58, r);
        xfer(0, 8'h00, r); chk("read_b0", r, 8'hA5);
        xfer(0, 8'h00, r); chk("read_b1", r, 8'hA4);
        xfer(0, 8'h00, r); chk("read_b2", r, 8'hA7);
        xfer(0, 8'h00, r); chk("read_b3", r, 8'hA6);
        desel(0);
        chk("read_addr", b0.ioctl_addr, 4);
        chk("read_oe_off", b0.spi_do_oe, 0);
        cmd2(0, 8'h57, 8'hFF);
        chk("restart_addr", b0.ioctl_addr, 0);
        sel(0);
        xfer(0, 8'h58, r);
        xfer(0, 8'h00, r); chk("abort_b0", r, 8'hA5);
        xfer(0, 8'h00, r); chk("abort_b1", r, 8'hA4);
        bits(0, 8'h00, 5, r);
        desel(0);
        chk("abort_addr", b0.ioctl_addr, 2);
        sel(0);
        xfer(0, 8'h58, r);
        xfer(0, 8'h00, r); chk("resume_b2", r, 8'hA7);
        desel(0);
        chk("resume_addr", b0.ioctl_addr, 3);
        rd_cnt = 0; oe_cnt = 0;
        sel(0);
        xfer(0, 8'h12, r);
        xfer(0, 8'h00, r); chk("unk_miso", r, 8'hFF);
        desel(0);
        chk("unk_rd", rd_cnt, 0);
        chk("unk_oe", oe_cnt, 0);
        chk("unk_addr", b0.ioctl_addr, 3);
        sel(0);
        xfer(0, 8'h58, r);
        xfer(0, 8'h00, r);
        bits(0, 8'h00, 3, r);
        chk("mid_oe", b0.spi_do_oe, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", b0.spi_do_oe, 0);
        chk("mid_rst_up", b0.uploading, 0);
        chk("mid_rst_addr", b0.ioctl_addr, 0);
        chk("mid_rst_do", b0.spi_do, 1);
        ss[0] = 1'b1;
        #50;
        rst_n = 1'b1;
        #50;
        cmd2(1, 8'h57, 8'hFF);
        sel(1);
        xfer(1, 8'h58, r);
        for (int i = 0; i < 18; i++) begin
            xfer(1, 8'h00, r);
            if (i == 15) chk("wrap_b15", r, 8'hAA);
            if (i == 16) chk("wrap_b16", r, 8'hA5);
            if (i == 17) chk("wrap_b17", r, 8'hA4);
        end
        desel(1);
        chk("wrap_addr", b1.ioctl_addr, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
